// File: rtl/lvds_word_align_4link_pkg.sv
// Shared constants, FSM state type and rotation helper for the LVDS word aligner.
package lvds_word_align_4link_pkg;

  localparam int unsigned LANE_BITS     = 7;
  localparam int unsigned DATA_LANES    = 4;
  localparam int unsigned LINK_BITS_IN  = 35;
  localparam int unsigned LINK_BITS_OUT = 28;

  localparam logic [LANE_BITS-1:0] LVDS_CLK_PATTERN = 7'b1100011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  function automatic logic [2:0] next_rot(input logic [2:0] r);
    return (r == 3'd6) ? 3'd0 : r + 3'd1;
  endfunction

endpackage

// File: rtl/lvds_link_align.sv
// One LVDS link: two-stage capture/rotate pipeline plus the word-phase lock FSM.
module lvds_link_align
  import lvds_word_align_4link_pkg::*;
#(
  parameter logic [LANE_BITS-1:0] CLK_PATTERN = LVDS_CLK_PATTERN,
  parameter int unsigned          LOCK_CNT    = 16,
  parameter int unsigned          ERR_CNT     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     din_valid_i,
  input  logic [LINK_BITS_IN-1:0]  din_i,
  output logic [LINK_BITS_OUT-1:0] data_o,
  output logic                     lock_o,
  output logic                     lock_next_o,
  output logic [2:0]               rot_o
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] ERR_LAST  = 8'(ERR_CNT - 1);

  logic [LINK_BITS_IN-1:0]  cur_q, prev_q;
  logic [LINK_BITS_IN-1:0]  aligned;
  logic [LINK_BITS_OUT-1:0] data_q;
  logic                     match_q;
  logic                     vld1_q, vld2_q;
  logic [13:0]              cat, sh;

  align_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d, err_q, err_d;
  logic [2:0]   rot_q, rot_d;

  always_comb begin
    aligned = '0;
    cat     = '0;
    sh      = '0;
    for (int unsigned k = 0; k < DATA_LANES + 1; k++) begin
      cat = {prev_q[LANE_BITS*k +: LANE_BITS], cur_q[LANE_BITS*k +: LANE_BITS]};
      sh  = cat >> rot_q;
      aligned[LANE_BITS*k +: LANE_BITS] = sh[LANE_BITS-1:0];
    end
  end

  // vld1/vld2 follow the data through the pipe so the FSM only judges
  // match flags derived from words captured while the deserializer was ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q   <= '0;
      prev_q  <= '0;
      data_q  <= '0;
      match_q <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
    end else begin
      cur_q   <= din_i;
      prev_q  <= cur_q;
      data_q  <= aligned[LINK_BITS_OUT-1:0];
      match_q <= (aligned[LINK_BITS_IN-1 -: LANE_BITS] == CLK_PATTERN);
      vld1_q  <= din_valid_i;
      vld2_q  <= vld1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      err_q   <= '0;
      rot_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rot_q   <= rot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rot_d   = rot_q;
    if (!din_valid_i) begin
      state_d = SEARCH;
      cnt_d   = '0;
      err_d   = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (vld2_q) begin
            if (match_q) begin
              if (cnt_q == LOCK_LAST) begin
                state_d = LOCKED;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end else begin
              cnt_d   = '0;
              rot_d   = next_rot(rot_q);
              state_d = SLIP;
            end
          end
        end
        SLIP: state_d = SEARCH;
        LOCKED: begin
          if (vld2_q) begin
            if (match_q) begin
              err_d = '0;
            end else if (err_q == ERR_LAST) begin
              state_d = SEARCH;
              cnt_d   = '0;
              err_d   = '0;
            end else begin
              err_d = err_q + 8'd1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign data_o      = data_q;
  assign lock_o      = (state_q == LOCKED);
  assign lock_next_o = (state_d == LOCKED);
  assign rot_o       = rot_q;

endmodule

// File: rtl/lvds_word_align_4link.sv
// Word-boundary aligner for PIXEL_NUM LVDS links feeding the LVDS-to-RGB unpacker.
module lvds_word_align_4link
  import lvds_word_align_4link_pkg::*;
#(
  parameter int unsigned          PIXEL_NUM   = 4,
  parameter logic [LANE_BITS-1:0] CLK_PATTERN = LVDS_CLK_PATTERN,
  parameter int unsigned          LOCK_CNT    = 16,
  parameter int unsigned          ERR_CNT     = 4
) (
  input  logic                                CLK_I,
  input  logic                                RSTN_I,
  input  logic                                DIN_VALID_I,
  input  logic [PIXEL_NUM*LINK_BITS_IN-1:0]   DIN_I,
  output logic [PIXEL_NUM*LINK_BITS_OUT-1:0]  DATA_O,
  output logic                                VALID_O,
  output logic [PIXEL_NUM-1:0]                LOCK_O,
  output logic [PIXEL_NUM*3-1:0]              ROT_O
);

  logic [PIXEL_NUM-1:0] lock_next;
  logic                 valid_q;

  for (genvar g = 0; g < PIXEL_NUM; g++) begin : g_link
    lvds_link_align #(
      .CLK_PATTERN(CLK_PATTERN),
      .LOCK_CNT   (LOCK_CNT),
      .ERR_CNT    (ERR_CNT)
    ) u_link (
      .clk_i      (CLK_I),
      .rst_ni     (RSTN_I),
      .din_valid_i(DIN_VALID_I),
      .din_i      (DIN_I[LINK_BITS_IN*g +: LINK_BITS_IN]),
      .data_o     (DATA_O[LINK_BITS_OUT*g +: LINK_BITS_OUT]),
      .lock_o     (LOCK_O[g]),
      .lock_next_o(lock_next[g]),
      .rot_o      (ROT_O[3*g +: 3])
    );
  end

  // Registered from the links' next-state so VALID_O moves on the same edge as LOCK_O.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) valid_q <= 1'b0;
    else         valid_q <= DIN_VALID_I & (&lock_next);
  end

  assign VALID_O = valid_q;

endmodule

// File: tb/tb_lvds_word_align_4link.sv
// Directed, scoreboard-driven bench for the 4-link LVDS word aligner.
module tb_lvds_word_align_4link;
  import lvds_word_align_4link_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          din_valid = 1'b0;
  logic [139:0]  din = '0;
  logic [111:0]  data_o;
  logic          valid_o;
  logic [3:0]    lock_o;
  logic [11:0]   rot_o;

  always #5 clk = ~clk;

  lvds_word_align_4link #(
    .PIXEL_NUM(4),
    .LOCK_CNT (16),
    .ERR_CNT  (4)
  ) dut (
    .CLK_I      (clk),
    .RSTN_I     (rstn),
    .DIN_VALID_I(din_valid),
    .DIN_I      (din),
    .DATA_O     (data_o),
    .VALID_O    (valid_o),
    .LOCK_O     (lock_o),
    .ROT_O      (rot_o)
  );

  int errors = 0;
  int checks = 0;
  int n = 0;
  logic [2:0] trot [4];
  int c_link = -1, c_from = 0, c_to = -1;
  bit zero_din = 1'b1, chk_data = 1'b0;
  logic [111:0] exp_q [$];

  task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Transmitted (true) word of link l, lane (4 = clock lane), stream index idx.
  function automatic logic [6:0] tword(input int l, input int lane, input int idx);
    if (lane == 4)
      return (l == c_link && idx >= c_from && idx <= c_to) ? 7'h00 : LVDS_CLK_PATTERN;
    return 7'((idx + 13 * l + 29 * lane) & 'h7f);
  endfunction

  // Raw deserializer word whose boundary is offset so rotation r recovers word a.
  function automatic logic [6:0] rawword(input logic [6:0] a, input logic [6:0] b, input logic [2:0] r);
    logic [13:0] c;
    c = {a, b};
    c = c >> (3'd7 - r);
    return c[6:0];
  endfunction

  task automatic step();
    logic [111:0] e;
    @(negedge clk);
    e = '0;
    for (int l = 0; l < 4; l++) begin
      for (int lane = 0; lane < 5; lane++) begin
        if (zero_din) begin
          din[35*l + 7*lane +: 7] = 7'h00;
        end else begin
          din[35*l + 7*lane +: 7] = rawword(tword(l, lane, n), tword(l, lane, n + 1), trot[l]);
          if (lane < 4) e[28*l + 7*lane +: 7] = tword(l, lane, n);
        end
      end
    end
    exp_q.push_back(e);
    n++;
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      if (chk_data) check("data", data_o, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rstn = 1'b1;
  endtask

  task automatic wait_lock(input int bound, output int steps, output bit early);
    steps = 0;
    early = 1'b0;
    while (steps < bound) begin
      step();
      steps++;
      if (valid_o === 1'b1 && lock_o !== 4'hF) early = 1'b1;
      if (lock_o === 4'hF) break;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  steps;
    bit  early;
    bit  dropped;
    logic [11:0] rot_skew;

    // Reset hold, then idle with DIN_VALID_I low.
    #2 rstn = 1'b0;
    #20;
    check("rst_data",  data_o,  112'd0);
    check("rst_valid", valid_o, 112'd0);
    check("rst_lock",  lock_o,  112'd0);
    check("rst_rot",   rot_o,   112'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_data",  data_o,  112'd0);
      check("idle_valid", valid_o, 112'd0);
      check("idle_lock",  lock_o,  112'd0);
      check("idle_rot",   rot_o,   112'd0);
    end

    // All links aligned at rotation 3.
    for (int l = 0; l < 4; l++) trot[l] = 3'd3;
    zero_din  = 1'b0;
    din_valid = 1'b1;
    wait_lock(100, steps, early);
    check("lock_cycle_rot3", (steps >= 23 && steps <= 25) ? 24 : steps, 112'd24);
    check("valid_with_lock", valid_o, 112'd1);
    check("valid_early_rot3", early, 112'd0);
    check("rot_rot3", rot_o, 112'h6DB);

    // Data integrity at rotation 3.
    chk_data = 1'b1;
    repeat (20) step();
    chk_data = 1'b0;

    // Three corrupted clock words on link 1: lock must hold.
    c_link = 1; c_from = n + 5; c_to = n + 7;
    for (int i = 0; i < 15; i++) begin
      step();
      check("hold_3err_lock",  lock_o,  112'hF);
      check("hold_3err_valid", valid_o, 112'd1);
    end

    // Four corrupted clock words: link 1 drops, then relocks at the same phase.
    c_from = n + 5; c_to = n + 8;
    dropped = 1'b0;
    for (int i = 0; i < 15 && !dropped; i++) begin
      step();
      if (lock_o[1] === 1'b0) dropped = 1'b1;
    end
    check("drop_4err_seen",  dropped, 112'd1);
    check("drop_4err_lock",  lock_o,  112'hD);
    check("drop_4err_valid", valid_o, 112'd0);
    wait_lock(18, steps, early);
    check("relock_4err",       lock_o, 112'hF);
    check("relock_4err_valid", valid_o, 112'd1);
    check("relock_4err_rot",   rot_o,  112'h6DB);
    c_link = -1;

    // One-cycle DIN_VALID_I dropout.
    din_valid = 1'b0;
    step();
    din_valid = 1'b1;
    check("vdrop_lock",  lock_o,  112'd0);
    check("vdrop_valid", valid_o, 112'd0);
    check("vdrop_rot",   rot_o,   112'h6DB);
    repeat (14) step();
    check("vdrop_no_early_lock", lock_o, 112'd0);
    wait_lock(10, steps, early);
    check("vdrop_relock", lock_o, 112'hF);

    // Per-link skew: links need rotations 0, 2, 5, 6.
    do_reset();
    trot[0] = 3'd0; trot[1] = 3'd2; trot[2] = 3'd5; trot[3] = 3'd6;
    rot_skew = {3'd6, 3'd5, 3'd2, 3'd0};
    din_valid = 1'b1;
    wait_lock(100, steps, early);
    check("lock_cycle_skew", (steps >= 29 && steps <= 31) ? 30 : steps, 112'd30);
    check("valid_early_skew", early, 112'd0);
    check("valid_skew", valid_o, 112'd1);
    check("rot_skew", rot_o, rot_skew);
    chk_data = 1'b1;
    repeat (10) step();
    chk_data = 1'b0;

    // Asynchronous reset during search.
    do_reset();
    for (int l = 0; l < 4; l++) trot[l] = 3'd3;
    din_valid = 1'b1;
    repeat (5) step();
    #2 rstn = 1'b0;
    #1;
    check("areset_data",  data_o,  112'd0);
    check("areset_valid", valid_o, 112'd0);
    check("areset_lock",  lock_o,  112'd0);
    check("areset_rot",   rot_o,   112'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
